dbg_trace_uart: RTL
===================

DBG_TRACE_UART -- requirements
Module: dbg_trace_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit, legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of trace records buffered, power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port retired  input  1  CPU instruction-retired strobe, one cycle per instruction.
REQ-006 SHALL have port halted  input  1  CPU halted flag.
REQ-007 SHALL have port pc  input  16  CPU program counter.
REQ-008 SHALL have port flags  input  4  CPU F register, upper nibble.
REQ-009 SHALL have ports a, b, c  input  8 each  CPU registers A, B, C.
REQ-010 SHALL have port tx  output  1  UART serial out, 8N1, LSB first, idle high.
REQ-011 SHALL have port busy  output  1  high while a frame is being transmitted.
REQ-012 SHALL have port overflow  output  1  sticky, set when a record is dropped.
REQ-013 SHALL have port drop_count  output  8  saturating count of dropped records.
REQ-014 SHALL have port fifo_level  output  5  records currently held, 0..FIFO_DEPTH.

Function
REQ-015 SHALL, on a rising edge with retired=1, push the record {halted, pc, flags, a, b, c} as sampled on that same edge.
REQ-016 SHALL, when retired=1 and the FIFO is full and no pop occurs that cycle, discard the record, set overflow, and increment drop_count, saturating at 8'hFF.
REQ-017 SHALL, on simultaneous push and pop with the FIFO full, accept the push; fifo_level stays FIFO_DEPTH.
REQ-018 SHALL implement TX states IDLE, START, DATA, STOP, with a 3-bit byte index 0..6 and a 3-bit bit index 0..7.
REQ-019 SHALL, in IDLE with fifo_level>0, pop the head record into a frame register and enter START; tx goes low on the next edge, giving one cycle from non-empty to start bit.
REQ-020 SHALL hold each START, DATA and STOP bit on tx for exactly CLKS_PER_BIT cycles, counted by a bit-period counter reloaded on every bit boundary.
REQ-021 SHALL transmit a 7-byte frame in this order: 8'hA5, pc[15:8], pc[7:0], {halted,3'b000,flags}, a, b, c.
REQ-022 SHALL, after the STOP bit of bytes 0..5, go to START of the next byte with no idle gap; after the STOP bit of byte 6, go to IDLE.
REQ-023 SHALL spend at least one cycle in IDLE between frames, so one frame occupies 70*CLKS_PER_BIT+1 cycles from pop to next pop.
REQ-024 SHALL drive busy=1 in START, DATA and STOP, and busy=0 in IDLE.
REQ-025 SHALL leave a frame in progress unaffected by FIFO pushes or drops.
REQ-026 SHALL update fifo_level on the edge after each push or pop, and SHALL keep wrap-around pointers of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-027 SHALL, while reset_n=0, immediately force tx=1, busy=0, overflow=0, drop_count=0, fifo_level=0, state IDLE, and empty the FIFO.
REQ-028 SHALL abort a frame in progress when reset asserts mid-frame; tx returns high with no completing bits, and that record is lost.
REQ-029 SHALL ignore retired on the first edge after reset_n deasserts only if it is not a clean rising edge; otherwise capture resumes on the first edge.
REQ-030 SHALL clear overflow and drop_count only by reset.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 SHALL verify single record: retired pulse with pc=16'h0150, flags=4'hB, a=8'h01, b=8'h02, c=8'h03, halted=0 -> tx decodes A5 01 50 0B 01 02 03; start bit begins 1 cycle after the push edge; busy high 280 cycles.
REQ-032 SHALL verify the halted bit: a record with halted=1, flags=4'h0 -> byte 3 = 8'h80.
REQ-033 SHALL verify overflow: 6 retired pulses on consecutive cycles while idle -> the first is popped immediately, 4 are buffered, 1 is dropped; overflow=1, drop_count=1, fifo_level=4; all 5 frames then transmit back-to-back in order.
REQ-034 SHALL verify saturation: 300 drops while the FIFO is full -> drop_count=8'hFF and no wrap.
REQ-035 SHALL verify reset mid-frame: reset_n low during byte 2 -> tx=1 and busy=0 at once, fifo_level=0; after release, a new pulse yields a complete frame starting with A5.
REQ-036 SHALL verify simultaneous push and pop: a pulse on the exact edge that pops with the FIFO full -> the record is accepted, fifo_level stays 4, drop_count is unchanged.

Source files
------------

// File: rtl/dbg_trace_uart.sv
// CPU trace-to-UART bridge: buffers retired-instruction records in a small FIFO
// and streams each one as a 7-byte 8N1 frame (A5 header, PC, halt/flags, A, B, C).
module dbg_trace_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        retired,
    input  logic        halted,
    input  logic [15:0] pc,
    input  logic [3:0]  flags,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  c,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic [4:0]  fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = 45;
    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [RW-1:0]   r_mem [FIFO_DEPTH];
    logic [RW-1:0]   r_frame;
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     w_level;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [15:0]     r_bit_cnt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      r_byte_idx;
    logic            w_bit_end;
    logic [7:0]      w_byte;

    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_level == (AW+1)'(FIFO_DEPTH));
    assign w_pop      = (r_state == S_IDLE) && (w_level != '0);
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_push     = retired && (!w_full || w_pop);
    assign w_drop     = retired && w_full && !w_pop;
    assign w_bit_end  = (r_bit_cnt == 16'd0);
    assign fifo_level = 5'(w_level);

    // Record storage: write on push, registered read straight into the frame.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {halted, pc, flags, a, b, c};
        end
        if (w_pop) begin
            r_frame <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (w_drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_state_next = S_START;
            S_START: if (w_bit_end) w_state_next = S_DATA;
            S_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_state_next = S_STOP;
            S_STOP:  if (w_bit_end) w_state_next = (r_byte_idx == 3'd6) ? S_IDLE : S_START;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt  <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
        end else if (w_pop) begin
            r_bit_cnt  <= BIT_RELOAD;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
        end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
                r_bit_cnt <= BIT_RELOAD;
                if (r_state == S_DATA) r_bit_idx  <= r_bit_idx + 3'd1;
                if (r_state == S_STOP) r_byte_idx <= r_byte_idx + 3'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt - 16'd1;
            end
        end
    end

    // Frame layout: header, PC high, PC low, {halted,000,flags}, A, B, C.
    always_comb begin
        w_byte = 8'hA5;
        case (r_byte_idx)
            3'd1:    w_byte = r_frame[43:36];
            3'd2:    w_byte = r_frame[35:28];
            3'd3:    w_byte = {r_frame[44], 3'b000, r_frame[27:24]};
            3'd4:    w_byte = r_frame[23:16];
            3'd5:    w_byte = r_frame[15:8];
            3'd6:    w_byte = r_frame[7:0];
            default: w_byte = 8'hA5;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_START: tx   = 1'b0;
            S_DATA:  tx   = w_byte[r_bit_idx];
            S_STOP:  tx   = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule
